// File: rtl/video_pkg.sv
// Shared definitions for the test-pattern video controller: FSM states,
// register map, register bit positions and 1080p60 frame geometry.
package video_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SYNC   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_PATTERN   = 3'd1;
    localparam logic [2:0] ADDR_STATUS    = 3'd2;
    localparam logic [2:0] ADDR_FRAME_CNT = 3'd3;
    localparam logic [2:0] ADDR_SETTLE    = 3'd4;

    localparam int CTRL_RUN_BIT    = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int PAT_SEL_LSB     = 0;
    localparam int PAT_BORDER_BIT  = 4;
    localparam int STAT_STATE_LSB  = 0;
    localparam int STAT_ERR_BIT    = 4;
    localparam int STAT_IRQ_BIT    = 5;

    localparam int H_TOTAL      = 2200;
    localparam int V_TOTAL      = 1125;
    localparam int FRAME_CYCLES = H_TOTAL * V_TOTAL;

endpackage

// File: rtl/video_ctrl_regs.sv
// Avalon-MM register bank for the video controller: CTRL, PATTERN shadow,
// STATUS with write-one-to-clear flags, FRAME_CNT readback and SETTLE.
module video_ctrl_regs
    import video_pkg::*;
#(
    parameter logic [3:0] SETTLE_DEFAULT = 4'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  state_t      state,
    input  logic [31:0] frame_cnt,
    input  logic        err_set,
    input  logic        irq_set,
    output logic        run,
    output logic        irq_en,
    output logic [1:0]  shadow_pattern,
    output logic        shadow_border,
    output logic [3:0]  settle,
    output logic        err,
    output logic        irq_pend,
    output logic        frame_irq
);

    logic        wr_ctrl;
    logic        wr_pattern;
    logic        wr_status;
    logic        wr_settle;
    logic [31:0] rd_data;
    logic        unused_wdata;

    assign wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
    assign wr_pattern = avs_write && (avs_address == ADDR_PATTERN);
    assign wr_status  = avs_write && (avs_address == ADDR_STATUS);
    assign wr_settle  = avs_write && (avs_address == ADDR_SETTLE);

    assign unused_wdata = ^avs_writedata[31:6];

    always_comb begin
        rd_data = '0;
        case (avs_address)
            ADDR_CTRL: begin
                rd_data[CTRL_RUN_BIT]    = run;
                rd_data[CTRL_IRQ_EN_BIT] = irq_en;
            end
            ADDR_PATTERN: begin
                rd_data[PAT_SEL_LSB +: 2] = shadow_pattern;
                rd_data[PAT_BORDER_BIT]   = shadow_border;
            end
            ADDR_STATUS: begin
                rd_data[STAT_STATE_LSB +: 3] = state;
                rd_data[STAT_ERR_BIT]        = err;
                rd_data[STAT_IRQ_BIT]        = irq_pend;
            end
            ADDR_FRAME_CNT: rd_data = frame_cnt;
            ADDR_SETTLE:    rd_data[3:0] = settle;
            default:        rd_data = '0;
        endcase
    end

    // Status flags: a hardware set in the same cycle as a software clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run            <= 1'b0;
            irq_en         <= 1'b0;
            shadow_pattern <= 2'd0;
            shadow_border  <= 1'b0;
            settle         <= SETTLE_DEFAULT;
            err            <= 1'b0;
            irq_pend       <= 1'b0;
            avs_readdata   <= '0;
        end else begin
            if (wr_ctrl) begin
                run    <= avs_writedata[CTRL_RUN_BIT];
                irq_en <= avs_writedata[CTRL_IRQ_EN_BIT];
            end
            if (wr_pattern) begin
                shadow_pattern <= avs_writedata[PAT_SEL_LSB +: 2];
                shadow_border  <= avs_writedata[PAT_BORDER_BIT];
            end
            if (wr_settle) begin
                settle <= avs_writedata[3:0];
            end
            err      <= err_set | (err & ~(wr_status & avs_writedata[STAT_ERR_BIT]));
            irq_pend <= irq_set | (irq_pend & ~(wr_status & avs_writedata[STAT_IRQ_BIT]));
            if (avs_read) begin
                avs_readdata <= rd_data;
            end
        end
    end

    assign frame_irq = irq_pend & irq_en;

endmodule

// File: rtl/video_pattern_ctrl.sv
// Sequencer for the 1080p60 test-pattern generator with frame-aligned pattern
// commit and frame counting. Define VIDEO_CTRL_TIMEOUT_EN for the lost-vsync watchdog.
//
//   state  | meaning
//   OFF    | generator held in reset, output blanked
//   SYNC   | generator released, waiting for first vsync
//   SETTLE | blanking the first SETTLE frames after sync
//   RUN    | video live, frames counted, irq per frame
//   STOP   | blanked, waiting for a frame edge to drop the generator
module video_pattern_ctrl
    import video_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4000000,
    parameter int unsigned SETTLE_DEFAULT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        vid_vs,
    output logic        gen_enable,
    output logic        blank,
    output logic [1:0]  pattern_sel,
    output logic        border_en,
    output logic        frame_irq
);

    state_t      state, state_d;
    logic        vs_q;
    logic        vs_fall;
    logic [3:0]  settle_cnt, settle_d;
    logic [31:0] frame_cnt, frame_d;
    logic        gen_d, blank_d;
    logic        commit;
    logic        irq_set, err_set;
    logic        timeout;

    logic        run, irq_en;
    logic [1:0]  shadow_pattern;
    logic        shadow_border;
    logic [3:0]  settle_val;
    logic        err, irq_pend;

    video_ctrl_regs #(
        .SETTLE_DEFAULT (4'(SETTLE_DEFAULT))
    ) u_regs (
        .clk            (clk),
        .reset          (reset),
        .avs_address    (avs_address),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .state          (state),
        .frame_cnt      (frame_cnt),
        .err_set        (err_set),
        .irq_set        (irq_set),
        .run            (run),
        .irq_en         (irq_en),
        .shadow_pattern (shadow_pattern),
        .shadow_border  (shadow_border),
        .settle         (settle_val),
        .err            (err),
        .irq_pend       (irq_pend),
        .frame_irq      (frame_irq)
    );

    assign vs_fall = vs_q & ~vid_vs;

`ifdef VIDEO_CTRL_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Down-counter reloaded while idle and on every frame edge; terminal count = lost sync.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= TMO_LOAD;
        end else if ((state == ST_OFF) || vs_fall) begin
            tmo_cnt <= TMO_LOAD;
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign timeout = (state != ST_OFF) && (tmo_cnt == '0);
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_d  = state;
        settle_d = settle_cnt;
        frame_d  = frame_cnt;
        irq_set  = 1'b0;
        err_set  = 1'b0;
        commit   = vs_fall && ((state == ST_SYNC) || (state == ST_SETTLE) || (state == ST_RUN));

        case (state)
            ST_OFF: begin
                if (run && !err) begin
                    state_d = ST_SYNC;
                    frame_d = '0;
                end
            end
            ST_SYNC: begin
                if (!run) begin
                    state_d = ST_OFF;
                end else if (vs_fall) begin
                    settle_d = settle_val;
                    state_d  = (settle_val == 4'd0) ? ST_RUN : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!run) begin
                    state_d = ST_STOP;
                end else if (vs_fall) begin
                    settle_d = settle_cnt - 1'b1;
                    if (settle_cnt <= 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (vs_fall) begin
                    frame_d = frame_cnt + 1'b1;
                    irq_set = 1'b1;
                end
                if (!run) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (vs_fall) begin
                    state_d = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase

        if (timeout) begin
            state_d = ST_OFF;
            err_set = 1'b1;
        end

        gen_d   = (state_d != ST_OFF);
        // Unblank only once RUN has been held for a full cycle; any exit blanks at once.
        blank_d = !((state == ST_RUN) && (state_d == ST_RUN));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_OFF;
            vs_q        <= 1'b1;
            settle_cnt  <= 4'd0;
            frame_cnt   <= '0;
            gen_enable  <= 1'b0;
            blank       <= 1'b1;
            pattern_sel <= 2'd0;
            border_en   <= 1'b0;
        end else begin
            state      <= state_d;
            vs_q       <= vid_vs;
            settle_cnt <= settle_d;
            frame_cnt  <= frame_d;
            gen_enable <= gen_d;
            blank      <= blank_d;
            if (commit) begin
                pattern_sel <= shadow_pattern;
                border_en   <= shadow_border;
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_ctrl.sv
// Randomized self-checking bench for video_pattern_ctrl against a frame-level model.
module tb_video_pattern_ctrl;
    import video_pkg::*;

    localparam int unsigned TMO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        vid_vs;
    logic        gen_enable;
    logic        blank;
    logic [1:0]  pattern_sel;
    logic        border_en;
    logic        frame_irq;

    int checks   = 0;
    int failures = 0;

    // Model: phase uses the architectural state numbering (0 OFF .. 4 STOP).
    int          m_phase;
    int          m_settle_reg;
    int          m_settle_cnt;
    int unsigned m_frames;
    bit          m_run, m_irq_en, m_irq;
    bit [1:0]    m_shadow_pat, m_pat;
    bit          m_shadow_bdr, m_bdr;

    video_pattern_ctrl #(
        .TIMEOUT_CYCLES (TMO),
        .SETTLE_DEFAULT (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .vid_vs        (vid_vs),
        .gen_enable    (gen_enable),
        .blank         (blank),
        .pattern_sel   (pattern_sel),
        .border_en     (border_en),
        .frame_irq     (frame_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase      = 0;
        m_settle_reg = 2;
        m_settle_cnt = 0;
        m_frames     = 0;
        m_run        = 1'b0;
        m_irq_en     = 1'b0;
        m_irq        = 1'b0;
        m_shadow_pat = 2'd0;
        m_pat        = 2'd0;
        m_shadow_bdr = 1'b0;
        m_bdr        = 1'b0;
    endtask

    task automatic edge_model();
        if (m_phase >= 1 && m_phase <= 3) begin
            m_pat = m_shadow_pat;
            m_bdr = m_shadow_bdr;
        end
        case (m_phase)
            1: begin
                m_settle_cnt = m_settle_reg;
                m_phase = (m_settle_reg == 0) ? 3 : 2;
            end
            2: begin
                m_settle_cnt--;
                if (m_settle_cnt == 0) m_phase = 3;
            end
            3: begin
                m_frames++;
                m_irq = 1'b1;
            end
            4: begin
                m_phase = m_run ? 1 : 0;
                if (m_run) m_frames = 0;
            end
            default: ;
        endcase
    endtask

    task automatic wr_model(input logic [2:0] a, input logic [31:0] d, input bit irq_set_now);
        if (a == ADDR_CTRL) begin
            m_run    = d[0];
            m_irq_en = d[1];
            if (!m_run) begin
                if (m_phase == 1) m_phase = 0;
                else if (m_phase == 2 || m_phase == 3) m_phase = 4;
            end else if (m_phase == 0) begin
                m_phase  = 1;
                m_frames = 0;
            end
        end else if (a == ADDR_PATTERN) begin
            m_shadow_pat = d[1:0];
            m_shadow_bdr = d[4];
        end else if (a == ADDR_STATUS) begin
            if (d[5] && !irq_set_now) m_irq = 1'b0;
        end else if (a == ADDR_SETTLE) begin
            m_settle_reg = int'(d[3:0]);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        wr_model(a, d, 1'b0);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic vs_edge();
        vid_vs = 1'b0;
        @(negedge clk);
        vid_vs = 1'b1;
        edge_model();
    endtask

    task automatic wr_at_edge(input logic [2:0] a, input logic [31:0] d);
        bit set_now;
        set_now = (m_phase == 3);
        avs_address = a; avs_writedata = d; avs_write = 1'b1; vid_vs = 1'b0;
        @(negedge clk);
        avs_write = 1'b0; vid_vs = 1'b1;
        edge_model();
        wr_model(a, d, set_now);
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_pat"}, 32'(pattern_sel), 32'(m_pat));
        chk({tag, "_bdr"}, 32'(border_en), 32'(m_bdr));
        chk({tag, "_irq"}, 32'(frame_irq), 32'(m_irq & m_irq_en));
    endtask

    function automatic logic [31:0] status_exp();
        return 32'(m_phase) | (32'(m_irq) << 5);
    endfunction

    initial begin
        logic [31:0] r;
        logic [31:0] p;
        int          s;
        int          nf;

        reset = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
        avs_read = 1'b0; vid_vs = 1'b1;
        model_reset();
        cyc(3);
        chk("rst_gen",   32'(gen_enable), 0);
        chk("rst_blank", 32'(blank), 1);
        chk("rst_pat",   32'(pattern_sel), 0);
        chk("rst_bdr",   32'(border_en), 0);
        chk("rst_irq",   32'(frame_irq), 0);
        chk("rst_rdata", avs_readdata, 0);
        reset = 1'b0;
        cyc(1);
        rd(ADDR_SETTLE, r); chk("rst_settle", r, 2);
        rd(ADDR_STATUS, r); chk("rst_status", r, 0);
        rd(ADDR_CTRL, r);   chk("rst_ctrl", r, 0);

        // Startup with SETTLE=2: RUN on the third frame edge.
        p = $urandom;
        wr(ADDR_PATTERN, p);
        wr(ADDR_SETTLE, 2);
        wr(ADDR_CTRL, 1);
        chk("start_gen_pre", 32'(gen_enable), 0);
        cyc(1);
        chk("start_gen", 32'(gen_enable), 1);
        chk("start_blank", 32'(blank), 1);
        rd(ADDR_STATUS, r); chk("start_sync", r, 1);
        for (int k = 0; k < 3; k++) begin
            cyc($urandom_range(1, 6));
            vs_edge();
            chk("start_blank_edge", 32'(blank), 1);
            chk_outs("start");
            rd(ADDR_STATUS, r); chk("start_state", r & 32'h7, (k < 2) ? 2 : 3);
        end
        chk("run_unblank", 32'(blank), 0);

        // Shadow commit in RUN, first write is 0x12.
        for (int i = 0; i < 3; i++) begin
            cyc($urandom_range(1, 10));
            p = (i == 0) ? 32'h12 : $urandom;
            wr(ADDR_PATTERN, p);
            chk_outs("shadow_hold");
            cyc($urandom_range(1, 10));
            vs_edge();
            chk_outs("shadow_commit");
            if (i == 0) begin
                chk("commit_0x12_pat", 32'(pattern_sel), 2);
                chk("commit_0x12_bdr", 32'(border_en), 1);
            end
            rd(ADDR_PATTERN, r);
            chk("pattern_rb", r, p & 32'h13);
        end
        rd(ADDR_FRAME_CNT, r); chk("frame_cnt_3", r, 3);
        chk("irq_masked", 32'(frame_irq), 0);
        rd(ADDR_STATUS, r); chk("status_run_irq", r, 32'h23);

        // Interrupt enable, W1C, and clear colliding with a new set.
        wr(ADDR_CTRL, 3);
        chk("irq_enabled", 32'(frame_irq), 1);
        wr(ADDR_STATUS, 32'h20);
        chk("irq_w1c", 32'(frame_irq), 0);
        cyc($urandom_range(2, 8));
        wr_at_edge(ADDR_STATUS, 32'h20);
        chk("irq_set_wins", 32'(frame_irq), 1);
        rd(ADDR_STATUS, r); chk("irq_set_wins_st", r, status_exp());
        p = $urandom | 32'h1;
        cyc(2);
        wr_at_edge(ADDR_PATTERN, p);
        chk_outs("edge_write_hold");
        cyc($urandom_range(2, 8));
        vs_edge();
        chk_outs("edge_write_next");
        avs_address = ADDR_PATTERN; avs_writedata = $urandom; avs_write = 1'b1; avs_read = 1'b1;
        @(negedge clk);
        avs_write = 1'b0; avs_read = 1'b0;
        chk("rd_wr_old", avs_readdata, (32'(m_shadow_bdr) << 4) | 32'(m_shadow_pat));
        wr_model(ADDR_PATTERN, avs_writedata, 1'b0);
        for (int a = 5; a < 8; a++) begin
            wr(3'(a), $urandom);
            rd(3'(a), r); chk("unmapped", r, 0);
        end
        wr(ADDR_FRAME_CNT, $urandom);
        rd(ADDR_FRAME_CNT, r); chk("frame_cnt_ro", r, m_frames);
        rd(ADDR_CTRL, r); chk("ctrl_rb", r, 3);

        // Stop mid-frame, re-arm run inside STOP.
        wr(ADDR_CTRL, 2);
        chk("stop_blank_pre", 32'(blank), 0);
        cyc(1);
        chk("stop_blank", 32'(blank), 1);
        cyc($urandom_range(3, 20));
        chk("stop_gen_hold", 32'(gen_enable), 1);
        wr(ADDR_CTRL, 3);
        cyc(2);
        rd(ADDR_STATUS, r); chk("stop_rearm_ignored", r & 32'h7, 4);
        vs_edge();
        chk("stop_gen_off", 32'(gen_enable), 0);
        chk_outs("stop");
        cyc(1);
        chk("restart_gen", 32'(gen_enable), 1);
        rd(ADDR_STATUS, r); chk("restart_sync", r, status_exp());
        rd(ADDR_FRAME_CNT, r); chk("restart_cnt_clr", r, 0);
        wr(ADDR_CTRL, 0);
        cyc(1);
        chk("sync_abort_gen", 32'(gen_enable), 0);
        rd(ADDR_STATUS, r); chk("sync_abort_st", r, status_exp());

        // Randomized sessions.
        for (int run_i = 0; run_i < 4; run_i++) begin
            s = $urandom_range(0, 4);
            wr(ADDR_SETTLE, 32'(s));
            if ($urandom_range(0, 1) == 1) wr(ADDR_PATTERN, $urandom);
            wr(ADDR_CTRL, 32'h1 | (32'($urandom_range(0, 1)) << 1));
            cyc(1);
            chk("rnd_gen", 32'(gen_enable), 1);
            for (int k = 0; k < 8 && m_phase != 3; k++) begin
                cyc($urandom_range(1, 6));
                if ($urandom_range(0, 2) == 0) wr(ADDR_PATTERN, $urandom);
                vs_edge();
                chk("rnd_settle_blank", 32'(blank), 1);
                chk_outs("rnd_settle");
            end
            cyc(1);
            chk("rnd_unblank", 32'(blank), 0);
            nf = $urandom_range(1, 4);
            for (int f = 0; f < nf; f++) begin
                cyc($urandom_range(1, 10));
                if ($urandom_range(0, 1) == 1) wr(ADDR_PATTERN, $urandom);
                chk_outs("rnd_hold");
                vs_edge();
                chk_outs("rnd_edge");
            end
            rd(ADDR_FRAME_CNT, r); chk("rnd_frames", r, m_frames);
            rd(ADDR_STATUS, r); chk("rnd_status", r, status_exp());
            wr(ADDR_CTRL, 32'(m_irq_en) << 1);
            cyc($urandom_range(1, 8));
            chk("rnd_stop_blank", 32'(blank), 1);
            vs_edge();
            chk("rnd_stop_gen", 32'(gen_enable), 0);
            wr(ADDR_STATUS, 32'h20);
            chk_outs("rnd_done");
        end

`ifdef VIDEO_CTRL_TIMEOUT_EN
        wr(ADDR_STATUS, 32'h30);
        wr(ADDR_CTRL, 1);
        cyc(1);
        chk("tmo_gen_on", 32'(gen_enable), 1);
        cyc(TMO - 1);
        chk("tmo_not_yet", 32'(gen_enable), 1);
        cyc(1);
        chk("tmo_gen_off", 32'(gen_enable), 0);
        chk("tmo_blank", 32'(blank), 1);
        m_phase = 0;
        rd(ADDR_STATUS, r); chk("tmo_status", r, 32'h10);
        cyc(10);
        chk("tmo_no_restart", 32'(gen_enable), 0);
        wr(ADDR_STATUS, 32'h10);
        cyc(1);
        chk("tmo_retry_gen", 32'(gen_enable), 1);
        m_phase = 1;
        wr(ADDR_CTRL, 0);
        cyc(1);
        chk("tmo_retry_off", 32'(gen_enable), 0);
`else
        wr(ADDR_STATUS, 32'h30);
        wr(ADDR_CTRL, 1);
        cyc(1);
        chk("notmo_gen_on", 32'(gen_enable), 1);
        cyc(TMO + 50);
        chk("notmo_wait", 32'(gen_enable), 1);
        rd(ADDR_STATUS, r); chk("notmo_status", r, 32'h01);
        wr(ADDR_CTRL, 0);
        cyc(1);
        chk("notmo_off", 32'(gen_enable), 0);
`endif

        // Async reset mid-line in RUN.
        wr(ADDR_SETTLE, 0);
        wr(ADDR_CTRL, 3);
        cyc(2);
        vs_edge();
        cyc(5);
        vs_edge();
        wr(ADDR_PATTERN, 32'h13);
        cyc(3);
        vs_edge();
        rd(ADDR_FRAME_CNT, r); chk("pre_rst_cnt", r, 2);
        chk_outs("pre_rst");
        cyc(4);
        #3 reset = 1'b1;
        #1;
        chk("arst_gen",   32'(gen_enable), 0);
        chk("arst_blank", 32'(blank), 1);
        chk("arst_pat",   32'(pattern_sel), 0);
        chk("arst_bdr",   32'(border_en), 0);
        chk("arst_irq",   32'(frame_irq), 0);
        chk("arst_rdata", avs_readdata, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cyc(1);
        rd(ADDR_FRAME_CNT, r); chk("arst_cnt", r, 0);
        rd(ADDR_STATUS, r);    chk("arst_status", r, 0);
        rd(ADDR_SETTLE, r);    chk("arst_settle", r, 2);
        rd(ADDR_CTRL, r);      chk("arst_ctrl", r, 0);
        cyc(3);
        chk("arst_gen_stays", 32'(gen_enable), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
